mul_iter: RTL and testbench
===========================

Name: mul_iter

Overview:
- Parametrised multi-cycle integer multiplier with valid/ready streams on both sides.
- Successor to the single-cycle mul path in the TinyRV1 processors: configurable width and bits retired per cycle.
- Adds RISC-V style high/low and signedness modes (MUL, MULH, MULHSU, MULHU).
- Sits beside the ALU in the next pipelined processor; the processor stalls on the handshake.

Parameters:
- nbits, 32, operand and result width; must be ≥ 2.
- bits_per_cycle, 1, multiplier bits consumed per CALC cycle; must divide nbits; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- istream_val  input  1  request valid.
- istream_rdy  output  1  unit can accept a request.
- istream_a  input  nbits  operand A (multiplicand).
- istream_b  input  nbits  operand B (multiplier).
- istream_mode  input  2  00=MUL low half; 01=MULH signed×signed high; 10=MULHSU signed A × unsigned B high; 11=MULHU unsigned high.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  consumer accepts result.
- ostream_result  output  nbits  selected half of the product.

Behaviour:
- States: IDLE, CALC, DONE. Reset, or rst high on any edge, goes to IDLE and clears the counter, accumulator and result registers to 0. Applies from any state, including mid-CALC and DONE. The aborted operation is discarded with no output.
- While rst is high: istream_rdy=0, ostream_val=0.
- IDLE:
  - istream_rdy=1, ostream_val=0.
  - On an edge with istream_val=1, latch |A| and |B| under the mode's signedness, the result sign (negative iff both operands are treated signed-negative differently), and the mode. Clear the 2*nbits accumulator, set counter=0, go to CALC.
  - MUL uses signed interpretation; the low half is identical either way.
- CALC:
  - istream_rdy=0, ostream_val=0.
  - Each cycle, add (multiplicand × low bits_per_cycle bits of the multiplier) shifted by counter*bits_per_cycle into the accumulator. Shift the multiplier right by bits_per_cycle, then counter += 1.
  - After N = nbits/bits_per_cycle cycles, register ostream_result and go to DONE. The result is the two's-complement negated product if the sign flag is set, then the low half for mode 00 or the high half otherwise.
  - No early termination: latency is fixed.
- Latency: request accepted at edge E0; ostream_val goes high in the cycle after edge E0+N. Example: nbits=32, bits_per_cycle=1 gives N=32.
- DONE:
  - ostream_val=1, istream_rdy=0.
  - ostream_result is held stable until an edge with ostream_rdy=1, then the state returns to IDLE.
  - No new request is accepted in the same cycle as the result handoff. The minimum issue interval is N+2 cycles.
- Inputs are sampled only on the accepting edge. Changing istream_a, istream_b or istream_mode afterwards has no effect.
- ostream_result keeps its last value in IDLE and CALC. Consumers qualify it with ostream_val only.
- Arithmetic: the full 2*nbits product is exact for all modes. Special cases:
  - MULH of the most negative value by itself uses magnitude 2^(nbits-1) unsigned, with no overflow.
  - MULHSU with B's MSB set treats B as a large unsigned value.

Test Plan:
- Basic (nbits=32, bpc=1): a=3, b=4, mode 00, ostream_rdy=1 → ostream_val rises exactly 32 cycles after accept, result 0x0000000C. Then istream_rdy=1 the cycle after handoff.
- Modes: (0xFFFFFFFF, 0xFFFFFFFF) gives 00 → 0x00000001 and 11 → 0xFFFFFFFE. (0x80000000, 0x80000000) with 01 → 0x40000000. (0xFFFFFFFF, 0x00000002) with 10 → 0xFFFFFFFF. (0x00000007, 0xFFFFFFFD) with 01 → 0xFFFFFFFF, and with 00 → 0xFFFFFFEB.
- Backpressure: hold ostream_rdy=0 for 5 cycles in DONE → result and ostream_val stable, istream_rdy=0 throughout. Assert ostream_rdy → IDLE next cycle. Toggle istream_a during CALC → result unaffected.
- Reset mid-operation: assert rst for 1 cycle at CALC cycle 10 → ostream_val never rises for that request, istream_rdy=1 the cycle after rst drops, ostream_result=0. A new request 5×6 → 0x0000001E.
- Parametrisation: nbits=8, bits_per_cycle=4, a=0xFF, b=0xFF. Mode 11 → 0xFE after latency exactly 2. Mode 00 → 0x01. Repeat with bits_per_cycle=8 → latency 1.
- Random: 200 back-to-back requests with random operands, modes and ostream_rdy stalls, checked against a 64-bit golden model in the bench.

Source files
------------

// File: rtl/mul_iter.sv
// Multi-cycle sign/magnitude multiplier with valid/ready handshakes.
// Retires bits_per_cycle multiplier bits per CALC cycle; supports MUL/MULH/MULHSU/MULHU.
module mul_iter #(
    parameter int nbits          = 32,
    parameter int bits_per_cycle = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] istream_a,
    input  logic [nbits-1:0] istream_b,
    input  logic [1:0]       istream_mode,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] ostream_result
);

    localparam int n_steps = nbits / bits_per_cycle;
    localparam int cnt_w   = (n_steps > 1) ? $clog2(n_steps) : 1;
    localparam logic [cnt_w-1:0] last_step = cnt_w'(n_steps - 1);

    generate
        if (nbits < 2 || bits_per_cycle < 1 || (nbits % bits_per_cycle) != 0) begin : g_bad_params
            $error("mul_iter: nbits must be >= 2 and divisible by bits_per_cycle");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [cnt_w-1:0]     counter;
    logic [2*nbits-1:0]   acc;
    logic [2*nbits-1:0]   mcand;
    logic [nbits-1:0]     mplier;
    logic                 neg;
    logic [1:0]           mode;

    // Operands are reduced to magnitudes; the sign is reapplied to the full product.
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [nbits-1:0] a_mag;
    logic [nbits-1:0] b_mag;

    assign a_signed = (istream_mode != 2'b11);
    assign b_signed = ~istream_mode[1];
    assign a_neg    = a_signed & istream_a[nbits-1];
    assign b_neg    = b_signed & istream_b[nbits-1];
    assign a_mag    = a_neg ? -istream_a : istream_a;
    assign b_mag    = b_neg ? -istream_b : istream_b;

    logic [bits_per_cycle-1:0] digit;
    logic [2*nbits-1:0]        partial;
    logic [2*nbits-1:0]        acc_sum;
    logic [2*nbits-1:0]        product;

    // mcand is pre-shifted each step, so it already carries the counter*bits_per_cycle weight.
    assign digit   = mplier[bits_per_cycle-1:0];
    assign partial = mcand * (2*nbits)'(digit);
    assign acc_sum = acc + partial;
    assign product = neg ? -acc_sum : acc_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    istream_rdy = 1'b1;
                    if (istream_val) state_next = CALC;
                end
                CALC: begin
                    if (counter == last_step) state_next = DONE;
                end
                DONE: begin
                    ostream_val = 1'b1;
                    if (ostream_rdy) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter        <= '0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            neg            <= 1'b0;
            mode           <= 2'b00;
            ostream_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val) begin
                        mcand   <= {{nbits{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        neg     <= a_neg ^ b_neg;
                        mode    <= istream_mode;
                        acc     <= '0;
                        counter <= '0;
                    end
                end
                CALC: begin
                    acc     <= acc_sum;
                    mcand   <= mcand << bits_per_cycle;
                    mplier  <= mplier >> bits_per_cycle;
                    counter <= counter + cnt_w'(1);
                    if (counter == last_step) begin
                        ostream_result <= (mode == 2'b00) ? product[nbits-1:0]
                                                          : product[2*nbits-1:nbits];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed testbench for mul_iter: a 32x1 instance plus two 8-bit instances (4 and 8 bits per cycle).
module tb_mul_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_val, i_rdy, o_val, o_rdy;
    logic [31:0] i_a, i_b, o_res;
    logic [1:0]  i_mode;

    logic       i_val8 [2];
    logic       i_rdy8 [2];
    logic [7:0] i_a8   [2];
    logic [7:0] i_b8   [2];
    logic [1:0] i_mode8[2];
    logic       o_val8 [2];
    logic       o_rdy8 [2];
    logic [7:0] o_res8 [2];

    int checks = 0;
    int passes = 0;

    mul_iter #(.nbits(32), .bits_per_cycle(1)) u32 (
        .clk(clk), .rst(rst),
        .istream_val(i_val), .istream_rdy(i_rdy),
        .istream_a(i_a), .istream_b(i_b), .istream_mode(i_mode),
        .ostream_val(o_val), .ostream_rdy(o_rdy), .ostream_result(o_res)
    );

    mul_iter #(.nbits(8), .bits_per_cycle(4)) u8a (
        .clk(clk), .rst(rst),
        .istream_val(i_val8[0]), .istream_rdy(i_rdy8[0]),
        .istream_a(i_a8[0]), .istream_b(i_b8[0]), .istream_mode(i_mode8[0]),
        .ostream_val(o_val8[0]), .ostream_rdy(o_rdy8[0]), .ostream_result(o_res8[0])
    );

    mul_iter #(.nbits(8), .bits_per_cycle(8)) u8b (
        .clk(clk), .rst(rst),
        .istream_val(i_val8[1]), .istream_rdy(i_rdy8[1]),
        .istream_a(i_a8[1]), .istream_b(i_b8[1]), .istream_mode(i_mode8[1]),
        .ostream_val(o_val8[1]), .ostream_rdy(o_rdy8[1]), .ostream_result(o_res8[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden product from sign/zero-extended 64-bit operands.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        logic [63:0] ae, be, p;
        ae = (m != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
        be = (m[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ae * be;
        return (m == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        int waited = 0;
        while (!i_rdy && waited < 100) begin
            tick();
            waited++;
        end
        checkOutput("accept_ready", i_rdy, 1);
        i_a = a; i_b = b; i_mode = m; i_val = 1'b1;
        tick();
        i_val = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!o_val && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic [31:0] exp);
        int lat;
        o_rdy = 1'b1;
        applyStimulus(a, b, m);
        waitResult(lat);
        checkOutput({tag, "_lat"}, lat, 32);
        checkOutput({tag, "_res"}, o_res, exp);
        tick();
    endtask

    task automatic run8(input string tag, input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] m, input logic [7:0] exp, input int explat);
        int lat = 0;
        o_rdy8[k] = 1'b1;
        checkOutput({tag, "_rdy"}, i_rdy8[k], 1);
        i_a8[k] = a; i_b8[k] = b; i_mode8[k] = m; i_val8[k] = 1'b1;
        tick();
        i_val8[k] = 1'b0;
        while (!o_val8[k] && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_lat"}, lat, explat);
        checkOutput({tag, "_res"}, o_res8[k], exp);
        tick();
    endtask

    initial begin
        int lat;
        int stall;
        logic seen;
        logic [31:0] ra, rb;
        logic [1:0]  rm;

        rst = 1'b1; i_val = 1'b0; o_rdy = 1'b0; i_a = '0; i_b = '0; i_mode = '0;
        for (int k = 0; k < 2; k++) begin
            i_val8[k] = 1'b0; o_rdy8[k] = 1'b0; i_a8[k] = '0; i_b8[k] = '0; i_mode8[k] = '0;
        end

        tick();
        checkOutput("rst_irdy", i_rdy, 0);
        checkOutput("rst_oval", o_val, 0);
        checkOutput("rst_irdy8", i_rdy8[0], 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_irdy", i_rdy, 1);
        checkOutput("post_rst_oval", o_val, 0);
        checkOutput("post_rst_res", o_res, 0);

        $display("[TB] basic and mode vectors");
        run32("basic", 32'd3, 32'd4, 2'b00, 32'h0000000C);
        checkOutput("basic_irdy_after", i_rdy, 1);
        checkOutput("basic_oval_after", o_val, 0);
        run32("mul_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001);
        run32("mulhu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE);
        run32("mulh_minmin", 32'h80000000, 32'h80000000, 2'b01, 32'h40000000);
        run32("mulhsu", 32'hFFFFFFFF, 32'h00000002, 2'b10, 32'hFFFFFFFF);
        run32("mulh_7m3", 32'h00000007, 32'hFFFFFFFD, 2'b01, 32'hFFFFFFFF);
        run32("mul_7m3", 32'h00000007, 32'hFFFFFFFD, 2'b00, 32'hFFFFFFEB);

        $display("[TB] backpressure and late input changes");
        o_rdy = 1'b0;
        applyStimulus(32'h12345678, 32'h00000010, 2'b00);
        tick();
        i_a = 32'hDEADBEEF; i_b = 32'h0; i_mode = 2'b11;
        tick();
        i_a = 32'h0;
        waitResult(lat);
        checkOutput("bp_lat", lat + 2, 32);
        checkOutput("bp_res", o_res, 32'h23456780);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_hold_val", o_val, 1);
            checkOutput("bp_hold_res", o_res, 32'h23456780);
            checkOutput("bp_hold_irdy", i_rdy, 0);
        end
        o_rdy = 1'b1;
        tick();
        checkOutput("bp_release_irdy", i_rdy, 1);
        checkOutput("bp_release_oval", o_val, 0);

        $display("[TB] reset during CALC");
        applyStimulus(32'h0000AAAA, 32'h00005555, 2'b00);
        repeat (9) tick();
        checkOutput("abort_oval_pre", o_val, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("abort_irdy", i_rdy, 1);
        checkOutput("abort_res", o_res, 0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            seen = seen | o_val;
        end
        checkOutput("abort_no_oval", seen, 0);
        run32("after_abort", 32'd5, 32'd6, 2'b00, 32'h0000001E);

        $display("[TB] 8-bit instances");
        run8("b4_mulhu", 0, 8'hFF, 8'hFF, 2'b11, 8'hFE, 2);
        run8("b4_mul", 0, 8'hFF, 8'hFF, 2'b00, 8'h01, 2);
        run8("b8_mulhu", 1, 8'hFF, 8'hFF, 2'b11, 8'hFE, 1);
        run8("b8_mul", 1, 8'hFF, 8'hFF, 2'b00, 8'h01, 1);
        run8("b4_mulh_neg", 0, 8'h80, 8'h03, 2'b01, 8'hFE, 2);

        $display("[TB] random requests");
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: begin ra = 32'h80000000; rb = 32'h80000000; end
                default: ;
            endcase
            rm = 2'($urandom_range(0, 3));
            o_rdy = 1'b0;
            applyStimulus(ra, rb, rm);
            waitResult(lat);
            checkOutput("rand_val", o_val, 1);
            checkOutput("rand_res", o_res, model(ra, rb, rm));
            stall = $urandom_range(0, 3);
            repeat (stall) tick();
            o_rdy = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
